// File: rtl/ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_md
// Purpose  : RV32 execute stage with MEM/WB forwarding, ALU operand select and
//            an iterative shift-add / restoring-divide RV32M unit.
// Revision : 1.0  initial release
// ============================================================================
module ex_stage_md #(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1,
    parameter int MD_EN  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic            flush_ex,
    input  logic [3:0]      ALUCode_ex,
    input  logic            MDEn_ex,
    input  logic [2:0]      MDOp_ex,
    input  logic            ALUSrcA_ex,
    input  logic [1:0]      ALUSrcB_ex,
    input  logic [XLEN-1:0] Imm_ex,
    input  logic [XLEN-1:0] PC_ex,
    input  logic [4:0]      rs1Addr_ex,
    input  logic [4:0]      rs2Addr_ex,
    input  logic [XLEN-1:0] rs1Data_ex,
    input  logic [XLEN-1:0] rs2Data_ex,
    input  logic [XLEN-1:0] ALUResult_mem,
    input  logic [4:0]      rdAddr_mem,
    input  logic            RegWrite_mem,
    input  logic [XLEN-1:0] RegWriteData_wb,
    input  logic [4:0]      rdAddr_wb,
    input  logic            RegWrite_wb,
    output logic [XLEN-1:0] Result_ex,
    output logic [XLEN-1:0] MemWriteData_ex,
    output logic            stall_ex
);

    // ALU operation encoding shared with the decoder
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    localparam int c_SHW = $clog2(XLEN);
    localparam int c_CW  = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    logic [XLEN-1:0]  w_rs1_fwd;
    logic [XLEN-1:0]  w_rs2_fwd;
    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_op_b;
    logic [XLEN-1:0]  w_alu;
    logic [c_SHW-1:0] w_shamt;
    logic             w_md_done;
    logic [XLEN-1:0]  w_md_result;

    generate
        if (FWD_EN != 0) begin : g_fwd
            // MEM stage holds the younger result, so it wins over WB
            always_comb begin
                w_rs1_fwd = rs1Data_ex;
                if (RegWrite_mem && (rdAddr_mem != 5'd0) && (rdAddr_mem == rs1Addr_ex))
                    w_rs1_fwd = ALUResult_mem;
                else if (RegWrite_wb && (rdAddr_wb != 5'd0) && (rdAddr_wb == rs1Addr_ex))
                    w_rs1_fwd = RegWriteData_wb;

                w_rs2_fwd = rs2Data_ex;
                if (RegWrite_mem && (rdAddr_mem != 5'd0) && (rdAddr_mem == rs2Addr_ex))
                    w_rs2_fwd = ALUResult_mem;
                else if (RegWrite_wb && (rdAddr_wb != 5'd0) && (rdAddr_wb == rs2Addr_ex))
                    w_rs2_fwd = RegWriteData_wb;
            end
        end else begin : g_no_fwd
            assign w_rs1_fwd = rs1Data_ex;
            assign w_rs2_fwd = rs2Data_ex;
        end
    endgenerate

    assign MemWriteData_ex = w_rs2_fwd;
    assign w_op_a = ALUSrcA_ex ? PC_ex : w_rs1_fwd;

    always_comb begin
        case (ALUSrcB_ex)
            2'd0:    w_op_b = w_rs2_fwd;
            2'd1:    w_op_b = Imm_ex;
            2'd2:    w_op_b = XLEN'(4);
            default: w_op_b = '0;
        endcase
    end

    assign w_shamt = w_op_b[c_SHW-1:0];

    always_comb begin
        case (ALUCode_ex)
            c_ALU_ADD:   w_alu = w_op_a + w_op_b;
            c_ALU_SUB:   w_alu = w_op_a - w_op_b;
            c_ALU_SLL:   w_alu = w_op_a << w_shamt;
            c_ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            c_ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            c_ALU_XOR:   w_alu = w_op_a ^ w_op_b;
            c_ALU_SRL:   w_alu = w_op_a >> w_shamt;
            c_ALU_SRA:   w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            c_ALU_OR:    w_alu = w_op_a | w_op_b;
            c_ALU_AND:   w_alu = w_op_a & w_op_b;
            c_ALU_PASSB: w_alu = w_op_b;
            default:     w_alu = w_op_a + w_op_b;
        endcase
    end

    generate
        if (MD_EN != 0) begin : g_md
            md_state_t       r_state;
            logic [c_CW-1:0] r_cnt;
            logic [2:0]      r_op;
            logic [XLEN-1:0] r_dvsr;
            logic [XLEN-1:0] r_hi;
            logic [XLEN-1:0] r_lo;
            logic            r_neg_q;
            logic            r_neg_r;

            logic            w_start;
            logic            w_a_neg;
            logic            w_b_neg;
            logic [XLEN-1:0] w_a_mag;
            logic [XLEN-1:0] w_b_mag;
            logic [XLEN:0]   w_mul_sum;
            logic [XLEN:0]   w_div_sh;
            logic            w_div_ge;
            logic [XLEN-1:0] w_div_diff;
            logic [2*XLEN-1:0] w_prod;
            logic [XLEN-1:0] w_quo;
            logic [XLEN-1:0] w_rem;

            assign w_start = (r_state == S_IDLE) && valid_ex && MDEn_ex && !flush_ex;

            // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM
            assign w_a_neg = w_rs1_fwd[XLEN-1] &&
                             ((MDOp_ex == 3'd1) || (MDOp_ex == 3'd2) ||
                              (MDOp_ex == 3'd4) || (MDOp_ex == 3'd6));
            assign w_b_neg = w_rs2_fwd[XLEN-1] &&
                             ((MDOp_ex == 3'd1) || (MDOp_ex == 3'd4) || (MDOp_ex == 3'd6));
            assign w_a_mag = w_a_neg ? -w_rs1_fwd : w_rs1_fwd;
            assign w_b_mag = w_b_neg ? -w_rs2_fwd : w_rs2_fwd;

            assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvsr} : '0);
            assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
            assign w_div_ge   = (w_div_sh >= {1'b0, r_dvsr});
            assign w_div_diff = w_div_sh[XLEN-1:0] - r_dvsr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_op    <= '0;
                    r_dvsr  <= '0;
                    r_hi    <= '0;
                    r_lo    <= '0;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_start) begin
                                r_op    <= MDOp_ex;
                                r_dvsr  <= w_b_mag;
                                r_hi    <= '0;
                                r_lo    <= w_a_mag;
                                // a zero divisor keeps the all-ones quotient un-negated
                                r_neg_q <= (w_a_neg ^ w_b_neg) &&
                                           !(MDOp_ex[2] && (w_rs2_fwd == '0));
                                r_neg_r <= w_a_neg;
                                r_cnt   <= c_CW'(XLEN);
                                r_state <= S_BUSY;
                            end
                        end
                        S_BUSY: begin
                            if (flush_ex) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end else begin
                                if (r_op[2]) begin
                                    r_hi <= w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0];
                                    r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                                end else begin
                                    r_hi <= w_mul_sum[XLEN:1];
                                    r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                                end
                                r_cnt <= r_cnt - c_CW'(1);
                                if (r_cnt == c_CW'(1))
                                    r_state <= S_DONE;
                            end
                        end
                        S_DONE:  r_state <= S_IDLE;
                        default: r_state <= S_IDLE;
                    endcase
                end
            end

            assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
            assign w_quo  = r_neg_q ? -r_lo : r_lo;
            assign w_rem  = r_neg_r ? -r_hi : r_hi;

            always_comb begin
                case (r_op)
                    3'd0:         w_md_result = w_prod[XLEN-1:0];
                    3'd1, 3'd2,
                    3'd3:         w_md_result = w_prod[2*XLEN-1:XLEN];
                    3'd4, 3'd5:   w_md_result = w_quo;
                    default:      w_md_result = w_rem;
                endcase
            end

            assign w_md_done = (r_state == S_DONE) && !flush_ex;
            assign stall_ex  = w_start || ((r_state == S_BUSY) && !flush_ex);
        end else begin : g_no_md
            assign w_md_done   = 1'b0;
            assign w_md_result = '0;
            assign stall_ex    = 1'b0;
        end
    endgenerate

    assign Result_ex = w_md_done ? w_md_result : w_alu;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_md
// Purpose  : directed self-checking bench for ex_stage_md (full and no-M/no-fwd builds)
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage_md;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex, flush_ex, MDEn_ex, ALUSrcA_ex;
    logic [3:0]  ALUCode_ex;
    logic [2:0]  MDOp_ex;
    logic [1:0]  ALUSrcB_ex;
    logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, ALUResult_mem, RegWriteData_wb;
    logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
    logic        RegWrite_mem, RegWrite_wb;
    logic [31:0] Result_ex, MemWriteData_ex, result_nomd, memwd_nomd;
    logic        stall_ex, stall_nomd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.XLEN(32), .FWD_EN(1), .MD_EN(1)) u_dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush_ex(flush_ex),
        .ALUCode_ex(ALUCode_ex), .MDEn_ex(MDEn_ex), .MDOp_ex(MDOp_ex),
        .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .Imm_ex(Imm_ex), .PC_ex(PC_ex),
        .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rs1Data_ex(rs1Data_ex),
        .rs2Data_ex(rs2Data_ex), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
        .RegWrite_mem(RegWrite_mem), .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb),
        .RegWrite_wb(RegWrite_wb), .Result_ex(Result_ex), .MemWriteData_ex(MemWriteData_ex),
        .stall_ex(stall_ex)
    );

    ex_stage_md #(.XLEN(32), .FWD_EN(0), .MD_EN(0)) u_dut_nomd (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush_ex(flush_ex),
        .ALUCode_ex(ALUCode_ex), .MDEn_ex(MDEn_ex), .MDOp_ex(MDOp_ex),
        .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .Imm_ex(Imm_ex), .PC_ex(PC_ex),
        .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rs1Data_ex(rs1Data_ex),
        .rs2Data_ex(rs2Data_ex), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
        .RegWrite_mem(RegWrite_mem), .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb),
        .RegWrite_wb(RegWrite_wb), .Result_ex(result_nomd), .MemWriteData_ex(memwd_nomd),
        .stall_ex(stall_nomd)
    );

    task automatic clear_inputs();
        valid_ex = 0; flush_ex = 0; MDEn_ex = 0; MDOp_ex = 0; ALUCode_ex = 4'd0;
        ALUSrcA_ex = 0; ALUSrcB_ex = 2'd0; Imm_ex = 0; PC_ex = 0;
        rs1Addr_ex = 0; rs2Addr_ex = 0; rs1Data_ex = 0; rs2Data_ex = 0;
        ALUResult_mem = 0; rdAddr_mem = 0; RegWrite_mem = 0;
        RegWriteData_wb = 0; rdAddr_wb = 0; RegWrite_wb = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall_ex); end
        n_cmp++; if (Result_ex !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 00000000", Result_ex); end
        // start request while reset is asserted must be ignored
        valid_ex = 1; MDEn_ex = 1; rs1Addr_ex = 1; rs1Data_ex = 32'd9; rs2Addr_ex = 2; rs2Data_ex = 32'd3;
        @(posedge clk); #1;
        reset = 0; valid_ex = 0; MDEn_ex = 0;
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b0) begin n_err++; $display("FAIL reset_over_start got %b exp 0", stall_ex); end
    endtask

    task automatic test_forwarding();
        @(posedge clk); #1;
        clear_inputs();
        valid_ex = 1; ALUCode_ex = 4'd0; ALUSrcB_ex = 2'd3;
        rs1Addr_ex = 5; rs1Data_ex = 32'h100;
        RegWrite_mem = 1; rdAddr_mem = 5; ALUResult_mem = 32'h11;
        RegWrite_wb = 1; rdAddr_wb = 5; RegWriteData_wb = 32'h22;
        @(negedge clk);
        n_cmp++; if (Result_ex !== 32'h11) begin n_err++; $display("FAIL fwd_mem_wins got %h exp 00000011", Result_ex); end
        n_cmp++; if (result_nomd !== 32'h100) begin n_err++; $display("FAIL fwd_disabled got %h exp 00000100", result_nomd); end
        RegWrite_mem = 0;
        @(negedge clk);
        n_cmp++; if (Result_ex !== 32'h22) begin n_err++; $display("FAIL fwd_wb got %h exp 00000022", Result_ex); end
        rdAddr_wb = 6;
        @(negedge clk);
        n_cmp++; if (Result_ex !== 32'h100) begin n_err++; $display("FAIL fwd_none got %h exp 00000100", Result_ex); end
        rs1Addr_ex = 0; rs1Data_ex = 0; RegWrite_mem = 1; rdAddr_mem = 0; rdAddr_wb = 0;
        @(negedge clk);
        n_cmp++; if (Result_ex !== 32'h0) begin n_err++; $display("FAIL fwd_x0 got %h exp 00000000", Result_ex); end
        // store: rs2 forwarded from WB, address = rs1 + imm
        RegWrite_mem = 0; rs1Addr_ex = 3; rs1Data_ex = 32'h200; ALUSrcB_ex = 2'd1; Imm_ex = 32'h8;
        rs2Addr_ex = 7; rs2Data_ex = 32'h5; RegWrite_wb = 1; rdAddr_wb = 7; RegWriteData_wb = 32'hABCD;
        @(negedge clk);
        n_cmp++; if (MemWriteData_ex !== 32'hABCD) begin n_err++; $display("FAIL store_data got %h exp 0000abcd", MemWriteData_ex); end
        n_cmp++; if (Result_ex !== 32'h208) begin n_err++; $display("FAIL store_addr got %h exp 00000208", Result_ex); end
    endtask

    task automatic test_alu();
        logic [3:0]  code [7];
        logic        sa   [7];
        logic [1:0]  sb   [7];
        logic [31:0] a    [7];
        logic [31:0] b    [7];
        logic [31:0] exp  [7];
        code = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd10, 4'd9};
        sa   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sb   = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        a    = '{32'h0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'hF0F0_1234};
        b    = '{32'h0, 32'd3, 32'h1, 32'h1, 32'h4, 32'h12345000, 32'h0000_FFFF};
        exp  = '{32'h1004, 32'd7, 32'h1, 32'h0, 32'hF8000000, 32'h12345000, 32'h0000_1234};
        clear_inputs();
        valid_ex = 1; PC_ex = 32'h1000; rs1Addr_ex = 1; rs2Addr_ex = 2;
        for (int i = 0; i < 7; i++) begin
            ALUCode_ex = code[i]; ALUSrcA_ex = sa[i]; ALUSrcB_ex = sb[i];
            rs1Data_ex = a[i]; rs2Data_ex = b[i]; Imm_ex = b[i];
            @(negedge clk);
            n_cmp++;
            if (Result_ex !== exp[i]) begin
                n_err++; $display("FAIL alu_vec%0d got %h exp %h", i, Result_ex, exp[i]);
            end
        end
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int stalls;
        bit done;
        @(posedge clk); #1;
        clear_inputs();
        valid_ex = 1; MDEn_ex = 1; MDOp_ex = op;
        rs1Addr_ex = 1; rs2Addr_ex = 2; rs1Data_ex = a; rs2Data_ex = b;
        stalls = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_ex) stalls++;
            else begin
                done = 1;
                n_cmp++;
                if (Result_ex !== exp) begin
                    n_err++; $display("FAIL %s result got %h exp %h", name, Result_ex, exp);
                end
            end
            // forwarding noise after the start edge must not reach the latched operands
            if (i == 1) begin
                RegWrite_mem = 1; rdAddr_mem = 1; ALUResult_mem = 32'hDEADBEEF;
                RegWrite_wb = 1; rdAddr_wb = 2; RegWriteData_wb = 32'h1234;
            end
        end
        n_cmp++;
        if (!done || stalls != 33) begin
            n_err++; $display("FAIL %s stall_cycles got %0d exp 33 (done=%0d)", name, stalls, done);
        end
    endtask

    task automatic test_md_back_to_back();
        run_md(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1");
        run_md(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_m1");
        run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
        run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        run_md(3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, "mulh_m3x5");
        run_md(3'd0, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1, "mul_3xm5");
        run_md(3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, "div_by0");
        run_md(3'd6, 32'd7,        32'd0,        32'd7,        "rem_by0");
        run_md(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_by0");
        run_md(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_neg_by0");
        run_md(3'd5, 32'd7,        32'd0,        32'hFFFFFFFF, "divu_by0");
        run_md(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_md(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
        run_md(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
        run_md(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
        run_md(3'd5, 32'd100,      32'd7,        32'd14,       "divu_100_7");
        run_md(3'd7, 32'd100,      32'd7,        32'd2,        "remu_100_7");
    endtask

    task automatic test_flush();
        int bad;
        @(posedge clk); #1;
        clear_inputs();
        valid_ex = 1; MDEn_ex = 1; MDOp_ex = 3'd5; ALUSrcB_ex = 2'd3;
        rs1Addr_ex = 1; rs2Addr_ex = 2; rs1Data_ex = 32'd100; rs2Data_ex = 32'd7;
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b1) begin n_err++; $display("FAIL flush_start_stall got %b exp 1", stall_ex); end
        repeat (10) @(posedge clk);
        #1 flush_ex = 1;
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b0) begin n_err++; $display("FAIL flush_busy_stall got %b exp 0", stall_ex); end
        n_cmp++; if (Result_ex !== 32'd100) begin n_err++; $display("FAIL flush_busy_result got %h exp 00000064", Result_ex); end
        @(posedge clk); #1;
        flush_ex = 0; valid_ex = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_ex !== 1'b0 || Result_ex !== 32'd100) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL flush_no_result bad_cycles got %0d exp 0", bad); end
        // flush in the start cycle suppresses the start
        @(posedge clk); #1;
        valid_ex = 1; flush_ex = 1;
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b0) begin n_err++; $display("FAIL flush_start_cycle got %b exp 0", stall_ex); end
        @(posedge clk); #1;
        flush_ex = 0; valid_ex = 0;
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b0) begin n_err++; $display("FAIL flush_start_next got %b exp 0", stall_ex); end
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        clear_inputs();
        valid_ex = 1; MDEn_ex = 1; MDOp_ex = 3'd0;
        rs1Addr_ex = 1; rs2Addr_ex = 2; rs1Data_ex = 32'd6; rs2Data_ex = 32'd7;
        repeat (5) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0; valid_ex = 0; MDEn_ex = 0;
        @(negedge clk);
        n_cmp++; if (stall_ex !== 1'b0) begin n_err++; $display("FAIL reset_busy_stall got %b exp 0", stall_ex); end
    endtask

    task automatic test_md_disabled();
        int bad;
        @(posedge clk); #1;
        clear_inputs();
        valid_ex = 1; MDEn_ex = 1; MDOp_ex = 3'd4; ALUSrcB_ex = 2'd1; Imm_ex = 32'd5;
        rs1Addr_ex = 1; rs1Data_ex = 32'd40; rs2Addr_ex = 2; rs2Data_ex = 32'd3;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_nomd !== 1'b0 || result_nomd !== 32'd45) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL md_disabled bad_cycles got %0d exp 0", bad); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_alu();
        test_md_back_to_back();
        test_flush();
        test_reset_busy();
        test_md_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
